receive_req_handshake: RTL and testbench
========================================

// Module: receive_req_handshake
// PURPOSE
//  Upstream stage of the RECEIVE_REQ Avalon PIO. Takes the asynchronous request line from the peer board,
//  synchronises and glitch-filters it, and runs a 4-phase handshake between peer and CPU.
//  recv_req drives the PIO in_port. The CPU answers through a SEND_ACK PIO output (cpu_ack).
//  ack_to_peer closes the handshake back to the peer. Timeouts are flagged for software recovery.
// PARAMETERS
//  SYNC_STAGES     2      synchroniser flops on peer_req (>=2)
//  FILTER_CYCLES   4      consecutive stable cycles before the filtered level changes (>=1)
//  TIMEOUT_CYCLES  50000  max cycles spent in PENDING or ACKING before ERROR (>=2)
//  CNT_W           16     width of completed-handshake counter
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  peer_req     in   1      request from peer, asynchronous to clk
//  cpu_ack      in   1      CPU acknowledge level (from SEND_ACK PIO)
//  clear_err    in   1      one-cycle pulse, clears timeout_err
//  recv_req     out  1      request pending to CPU (to RECEIVE_REQ in_port)
//  ack_to_peer  out  1      acknowledge to peer
//  timeout_err  out  1      sticky timeout flag
//  busy         out  1      FSM not in IDLE
//  hs_count     out  CNT_W  completed handshakes, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync-released use): all outputs 0, sync chain 0, req_f=0, filter cnt 0, FSM=IDLE.
//  Sync: peer_req -> SYNC_STAGES flops -> req_s.
//  Filter: if req_s==req_f, cnt<=0; else cnt++; when cnt reaches FILTER_CYCLES-1 with req_s!=req_f:
//    req_f<=req_s, cnt<=0.
//  A pulse shorter than FILTER_CYCLES never reaches req_f.
//  Latency: peer_req edge -> req_f edge = SYNC_STAGES+FILTER_CYCLES cycles (+/-1 for metastability).
//  FSM (all outputs registered, update on the cycle after the transition condition):
//   IDLE:    req_f=1 & cpu_ack=0 -> PENDING. req_f=1 & cpu_ack=1 stays IDLE (stale CPU ack blocks).
//   PENDING: recv_req=1; cpu_ack=1 -> ACKING; tmr==TIMEOUT_CYCLES-1 -> ERROR.
//   ACKING:  recv_req=0, ack_to_peer=1; req_f=0 -> DONE; timeout -> ERROR.
//   DONE:    ack_to_peer=0; hs_count++ on entry; cpu_ack=0 -> IDLE. No timeout here.
//   ERROR:   recv_req=0, ack_to_peer=0; timeout_err<=1; req_f=0 & cpu_ack=0 -> IDLE.
//  tmr clears on every state change and counts only in PENDING/ACKING.
//  Simultaneous timeout and a valid advance in the same cycle: the advance wins.
//  req_f falling in PENDING (peer withdraws): return to IDLE; recv_req drops; no count.
//  clear_err clears timeout_err. If a new timeout sets it in the same cycle, the set wins.
//  hs_count wraps 0xFFFF -> 0x0000 with no flag. busy = (state!=IDLE).
//  Reset mid-handshake: immediate return to reset values; peer sees ack_to_peer drop asynchronously.
// STRUCTURE
//  Shared package soc1_hs_pkg: state enum (IDLE, PENDING, ACKING, DONE, ERROR), 3-bit encoding,
//    default timing constants.
//  One sub-module: sync_glitch_filter (SYNC_STAGES, FILTER_CYCLES; clk, reset_n, d_async -> q).
//    The FSM, timer and counter stay in the top module.
// TESTING
//  1 Full handshake: peer_req=1 -> recv_req=1 after <=SYNC_STAGES+FILTER_CYCLES+2 cycles;
//    cpu_ack=1 -> ack_to_peer=1, recv_req=0; peer_req=0 -> ack_to_peer=0;
//    cpu_ack=0 -> IDLE, hs_count=1.
//  2 Glitch: peer_req high for 3 cycles (FILTER_CYCLES=4) -> recv_req stays 0, busy stays 0.
//  3 Timeout: TIMEOUT_CYCLES=20, hold peer_req=1, no cpu_ack -> timeout_err=1 at cycle 20 of PENDING;
//    recv_req=0; release both -> IDLE; clear_err pulse -> timeout_err=0.
//  4 Stale ack: cpu_ack=1 before peer_req rises -> stays IDLE, recv_req=0;
//    drop cpu_ack -> PENDING.
//  5 Wrap: CNT_W=4, run 16 handshakes -> hs_count=0.
//  6 Reset asserted in ACKING -> ack_to_peer=0 and hs_count=0 with no clock edge; normal handshake after release.

Source files
------------

// File: rtl/soc1_hs_pkg.sv
// ---------------------------------------------------------------------------
// soc1_hs_pkg
//   Shared definitions for the peer/CPU request handshake blocks.
//   - hs_state_e : handshake FSM state, 3-bit encoding
//   - DEF_*      : default timing / width constants used as parameter defaults
// ---------------------------------------------------------------------------
package soc1_hs_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    ACKING  = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } hs_state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILTER_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/sync_glitch_filter.sv
// ---------------------------------------------------------------------------
// sync_glitch_filter
//   Brings an asynchronous level into the clk domain through a flop chain,
//   then only lets the filtered level follow it after FILTER_CYCLES
//   consecutive cycles of disagreement. Shorter pulses never reach q.
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   d_async  in  level from another clock domain
//   q        out synchronised, glitch-filtered level (registered)
// ---------------------------------------------------------------------------
module sync_glitch_filter
  import soc1_hs_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_async,
  output logic q
);

  localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCNT_W-1:0]      cnt;
  logic                   req_s;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Plain shift chain; only the last stage is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
    end
  end

  // cnt counts consecutive cycles where req_s disagrees with q; any
  // agreement restarts the count, so the change must be stable throughout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (req_s == q) begin
      cnt <= '0;
    end else if (cnt == FCNT_LAST) begin
      q   <= req_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + FCNT_W'(1);
    end
  end

endmodule

// File: rtl/receive_req_handshake.sv
// ---------------------------------------------------------------------------
// receive_req_handshake
//   Upstream stage of the RECEIVE_REQ PIO. Filters the peer request and runs
//   a 4-phase handshake: peer raises req -> CPU sees recv_req -> CPU acks ->
//   peer sees ack_to_peer -> peer drops req -> CPU drops ack.
//   PENDING and ACKING are guarded by a timer; expiry parks the FSM in ERROR
//   and raises a sticky timeout_err for software recovery.
// Ports
//   clk          in  system clock
//   reset_n      in  asynchronous active-low reset
//   peer_req     in  request from peer (asynchronous)
//   cpu_ack      in  CPU acknowledge level (SEND_ACK PIO)
//   clear_err    in  one-cycle pulse clearing timeout_err
//   recv_req     out request pending to CPU
//   ack_to_peer  out acknowledge to peer
//   timeout_err  out sticky timeout flag
//   busy         out FSM not in IDLE
//   hs_count     out completed handshakes, wrapping
// ---------------------------------------------------------------------------
module receive_req_handshake
  import soc1_hs_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             peer_req,
  input  logic             cpu_ack,
  input  logic             clear_err,
  output logic             recv_req,
  output logic             ack_to_peer,
  output logic             timeout_err,
  output logic             busy,
  output logic [CNT_W-1:0] hs_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  hs_state_e        state;
  logic [TMR_W-1:0] tmr;
  logic             req_f;

  sync_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .d_async(peer_req),
    .q      (req_f)
  );

  // Handshake FSM. Outputs are set alongside each transition so they are
  // registered and change together with the state. Advances are checked
  // before the timer so a valid advance beats a same-cycle timeout. The
  // clear_err default sits first so a same-cycle timeout set overrides it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tmr         <= '0;
      recv_req    <= 1'b0;
      ack_to_peer <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      hs_count    <= '0;
    end else begin
      if (clear_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // A CPU ack still high from a previous exchange blocks a new one.
          if (req_f && !cpu_ack) begin
            state    <= PENDING;
            tmr      <= '0;
            recv_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        PENDING: begin
          if (cpu_ack) begin
            state       <= ACKING;
            tmr         <= '0;
            recv_req    <= 1'b0;
            ack_to_peer <= 1'b1;
          end else if (!req_f) begin
            state    <= IDLE;
            tmr      <= '0;
            recv_req <= 1'b0;
            busy     <= 1'b0;
          end else if (tmr == TMR_LAST) begin
            state       <= ERROR;
            tmr         <= '0;
            recv_req    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ACKING: begin
          if (!req_f) begin
            state       <= DONE;
            tmr         <= '0;
            ack_to_peer <= 1'b0;
            hs_count    <= hs_count + CNT_W'(1);
          end else if (tmr == TMR_LAST) begin
            state       <= ERROR;
            tmr         <= '0;
            ack_to_peer <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        DONE: begin
          if (!cpu_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ERROR: begin
          // Wait for both sides to let go before accepting a new request.
          if (!req_f && !cpu_ack) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          tmr         <= '0;
          recv_req    <= 1'b0;
          ack_to_peer <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receive_req_handshake.sv
// ---------------------------------------------------------------------------
// tb_receive_req_handshake
//   Self-checking bench for receive_req_handshake. Expected handshake counts
//   are queued when a handshake is driven and compared whenever hs_count
//   moves; the remaining checks compare against constants derived from the
//   filter/timeout parameters.
// ---------------------------------------------------------------------------
module tb_receive_req_handshake;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_W          = 4;
  localparam int REQ_LAT_MAX    = SYNC_STAGES + FILTER_CYCLES + 2;

  localparam int SIG_RECV = 0;
  localparam int SIG_ACK  = 1;
  localparam int SIG_BUSY = 2;
  localparam int SIG_ERR  = 3;

  logic             clk;
  logic             reset_n;
  logic             peer_req;
  logic             cpu_ack;
  logic             clear_err;
  logic             recv_req;
  logic             ack_to_peer;
  logic             timeout_err;
  logic             busy;
  logic [CNT_W-1:0] hs_count;

  int num_checks;
  int num_failures;
  int exp_count;
  int exp_q[$];
  logic [CNT_W-1:0] last_count;

  receive_req_handshake #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .peer_req   (peer_req),
    .cpu_ack    (cpu_ack),
    .clear_err  (clear_err),
    .recv_req   (recv_req),
    .ack_to_peer(ack_to_peer),
    .timeout_err(timeout_err),
    .busy       (busy),
    .hs_count   (hs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drive all inputs at the falling edge, away from the active edge.
  task automatic applyStimulus(input logic p_req, input logic c_ack, input logic clr);
    @(negedge clk);
    peer_req  = p_req;
    cpu_ack   = c_ack;
    clear_err = clr;
  endtask

  function automatic logic pickSig(input int which);
    case (which)
      SIG_RECV: return recv_req;
      SIG_ACK:  return ack_to_peer;
      SIG_BUSY: return busy;
      default:  return timeout_err;
    endcase
  endfunction

  // Wait (bounded) for an output to reach a level; expiry is a failed check.
  task automatic waitSig(input int which, input logic level, input int budget,
                         input string tag, output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (pickSig(which) === level) break;
      if (cycles >= budget) begin
        checkOutput({tag, "_timeout"}, 1, 0);
        break;
      end
    end
  endtask

  // Scoreboard side: every movement of hs_count must match the next queued value.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_count = '0;
    end else if (hs_count !== last_count) begin
      if (exp_q.size() == 0) begin
        checkOutput("hs_count_unexpected", int'(hs_count), int'(last_count));
      end else begin
        checkOutput("hs_count_sb", int'(hs_count), exp_q.pop_front());
      end
      last_count = hs_count;
    end
  end

  task automatic startHandshake(input bit verbose);
    int cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitSig(SIG_RECV, 1'b1, REQ_LAT_MAX + 4, "recv_rise", cyc);
    if (verbose) begin
      checkOutput("req_latency_ok", int'(cyc <= REQ_LAT_MAX), 1);
      checkOutput("pending_busy", int'(busy), 1);
      checkOutput("pending_ack", int'(ack_to_peer), 0);
    end
  endtask

  task automatic finishHandshake(input bit verbose);
    int cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitSig(SIG_ACK, 1'b1, 4, "ack_rise", cyc);
    if (verbose) checkOutput("acking_recv", int'(recv_req), 0);
    exp_count = (exp_count + 1) % (1 << CNT_W);
    exp_q.push_back(exp_count);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitSig(SIG_ACK, 1'b0, REQ_LAT_MAX + 4, "ack_fall", cyc);
    if (verbose) checkOutput("done_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitSig(SIG_BUSY, 1'b0, 4, "idle_return", cyc);
  endtask

  task automatic resetDut();
    reset_n   = 1'b0;
    peer_req  = 1'b0;
    cpu_ack   = 1'b0;
    clear_err = 1'b0;
    exp_q.delete();
    exp_count = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    bit saw_recv;
    bit saw_busy;
    num_checks   = 0;
    num_failures = 0;
    exp_count    = 0;
    last_count   = '0;

    // Reset values
    reset_n   = 1'b0;
    peer_req  = 1'b0;
    cpu_ack   = 1'b0;
    clear_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_recv", int'(recv_req), 0);
    checkOutput("rst_ack", int'(ack_to_peer), 0);
    checkOutput("rst_err", int'(timeout_err), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_count", int'(hs_count), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full handshake
    $display("[TB] full handshake");
    startHandshake(1'b1);
    finishHandshake(1'b1);
    checkOutput("hs_count_after_one", int'(hs_count), 1);

    // Glitch shorter than the filter window
    $display("[TB] glitch rejection");
    saw_recv = 1'b0;
    saw_busy = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (FILTER_CYCLES - 1 - 1) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (recv_req) saw_recv = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    checkOutput("glitch_recv", int'(saw_recv), 0);
    checkOutput("glitch_busy", int'(saw_busy), 0);

    // Timeout in PENDING
    $display("[TB] pending timeout");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitSig(SIG_RECV, 1'b1, REQ_LAT_MAX + 4, "to_recv_rise", cyc);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (recv_req && !timeout_err) n++;
      else break;
    end
    checkOutput("timeout_cycles", n, TIMEOUT_CYCLES);
    checkOutput("timeout_err_set", int'(timeout_err), 1);
    checkOutput("timeout_recv", int'(recv_req), 0);
    checkOutput("timeout_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitSig(SIG_BUSY, 1'b0, REQ_LAT_MAX + 4, "err_exit", cyc);
    checkOutput("err_sticky", int'(timeout_err), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err_cleared", int'(timeout_err), 0);

    // Stale CPU ack blocks a new request
    $display("[TB] stale ack");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    saw_recv = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < REQ_LAT_MAX + 6; i++) begin
      @(negedge clk);
      if (recv_req) saw_recv = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    checkOutput("stale_recv", int'(saw_recv), 0);
    checkOutput("stale_busy", int'(saw_busy), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitSig(SIG_RECV, 1'b1, 3, "stale_release", cyc);
    checkOutput("stale_pending", int'(recv_req), 1);
    finishHandshake(1'b0);
    checkOutput("hs_count_after_stale", int'(hs_count), 2);

    // Counter wrap from a clean reset
    $display("[TB] counter wrap");
    resetDut();
    for (int i = 0; i < (1 << CNT_W); i++) begin
      startHandshake(1'b0);
      finishHandshake(1'b0);
    end
    checkOutput("hs_count_wrap", int'(hs_count), 0);

    // Asynchronous reset while in ACKING
    $display("[TB] reset in acking");
    startHandshake(1'b0);
    finishHandshake(1'b0);
    checkOutput("pre_reset_count", int'(hs_count), 1);
    startHandshake(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitSig(SIG_ACK, 1'b1, 4, "ack_before_reset", cyc);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_ack", int'(ack_to_peer), 0);
    checkOutput("async_rst_count", int'(hs_count), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    exp_q.delete();
    exp_count = 0;
    peer_req  = 1'b0;
    cpu_ack   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    startHandshake(1'b1);
    finishHandshake(1'b1);
    checkOutput("post_reset_count", int'(hs_count), 1);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
